// File: rtl/byte_joining_ctrl_pkg.sv
// byte_joining_ctrl_pkg: state encodings, width codes and lane-count mapping shared by the controller
package byte_joining_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, RUN = 2'd2} state_t;
  localparam logic [1:0] W_X1 = 2'd0;
  localparam logic [1:0] W_X2 = 2'd1;
  localparam int CNT_W = 4;
  function automatic logic [1:0] lanes_m1_of(input logic [1:0] w);
    return w == W_X1 ? 2'd0 : w == W_X2 ? 2'd1 : 2'd3;
  endfunction
endpackage

// File: rtl/byte_joining_ctrl_lane_sel_cnt.sv
// lane_sel_cnt: lane selector for the out-reg byte mux, wrapping at the last active lane
module lane_sel_cnt (
  input  logic       clk1Mhz,
  input  logic       reset,
  input  logic       step,
  input  logic       clear,
  input  logic [1:0] lanes_m1,
  output logic [1:0] crt_3,
  output logic       last
);
  assign last = crt_3 == lanes_m1;
  always_ff @(posedge clk1Mhz)
    if (reset || clear) crt_3 <= 2'd0;
    else if (step) crt_3 <= last ? 2'd0 : crt_3 + 2'd1;
endmodule

// File: rtl/byte_joining_ctrl.sv
// byte_joining_ctrl: word-sync FSM, hold/out occupancy and byte sequencing for the byte-joining datapath
module byte_joining_ctrl
  import byte_joining_ctrl_pkg::*;
#(
  parameter int STROBE_PERIOD = 4,
  parameter int ALIGN_CNT     = 2,
  parameter int MAX_GAP       = 8
) (
  input  logic       clk1Mhz,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] width_cfg,
  input  logic       word_strobe,
  input  logic       out_ready,
  output logic       load_lanes,
  output logic       advance,
  output logic [1:0] crt_3,
  output logic       byte_valid,
  output logic       busy,
  output logic       overrun,
  output logic       sync_lost
);
  localparam logic [CNT_W-1:0] SP  = CNT_W'(STROBE_PERIOD);
  localparam logic [CNT_W-1:0] GAP = CNT_W'(MAX_GAP);
  localparam logic [CNT_W-1:0] AC1 = CNT_W'(ALIGN_CNT - 1);
  state_t state, state_n;
  logic [1:0] lanes_m1, lanes_n;
  logic [CNT_W-1:0] per_cnt, per_n, good_cnt, good_n;
  logic hold_full, hold_n, out_full, out_n, last, acc, last_acc;
  logic in_run, lost, run_ok, adv_due, load, good_period, aligned;
  lane_sel_cnt u_sel (
    .clk1Mhz (clk1Mhz),
    .reset   (reset),
    .step    (acc),
    .clear   (!run_ok || adv_due),
    .lanes_m1(lanes_m1),
    .crt_3   (crt_3),
    .last    (last)
  );
  // per_cnt holds the length of the current strobe period; it restarts at 1 on each strobe
  always_comb begin
    acc         = byte_valid && out_ready;
    last_acc    = acc && last;
    in_run      = enable && state == RUN;
    lost        = in_run && (word_strobe ? per_cnt < SP : per_cnt >= GAP);
    run_ok      = in_run && !lost;
    adv_due     = run_ok && hold_full && (!out_full || last_acc);
    load        = run_ok && word_strobe && (!hold_full || adv_due);
    hold_n      = run_ok && (load || (hold_full && !adv_due));
    out_n       = run_ok && (adv_due || (out_full && !last_acc));
    good_period = word_strobe && per_cnt == SP;
    aligned     = state == ALIGN && good_period && good_cnt == AC1;
    state_n     = !enable ? IDLE : state == IDLE ? ALIGN : aligned ? RUN : lost ? ALIGN : state;
    per_n       = (!enable || state == IDLE) ? '0 : word_strobe ? CNT_W'(1) :
                  &per_cnt ? per_cnt : per_cnt + CNT_W'(1);
    good_n      = (enable && state == ALIGN && good_period && !aligned) ? good_cnt + CNT_W'(1) :
                  (enable && state == ALIGN && !word_strobe) ? good_cnt : '0;
    lanes_n     = (state == IDLE && enable) ? lanes_m1_of(width_cfg) : lanes_m1;
  end
  // byte_valid lags out_full on a fresh fill (copy cycle) but stays high across back-to-back words
  always_ff @(posedge clk1Mhz) begin
    if (reset) begin
      state      <= IDLE;
      lanes_m1   <= 2'd0;
      per_cnt    <= '0;
      good_cnt   <= '0;
      hold_full  <= 1'b0;
      out_full   <= 1'b0;
      load_lanes <= 1'b0;
      advance    <= 1'b0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      sync_lost  <= 1'b0;
    end else begin
      state      <= state_n;
      lanes_m1   <= lanes_n;
      per_cnt    <= per_n;
      good_cnt   <= good_n;
      hold_full  <= hold_n;
      out_full   <= out_n;
      load_lanes <= load;
      advance    <= adv_due;
      byte_valid <= out_full && out_n;
      busy       <= hold_n || out_n;
      overrun    <= run_ok && word_strobe && !load;
      sync_lost  <= lost;
    end
  end
endmodule

// File: tb/tb_byte_joining_ctrl.sv
// tb_byte_joining_ctrl: table-driven width runs plus hand-written corner sequences, byte scoreboard
module tb_byte_joining_ctrl;
  logic clk1Mhz = 1'b0;
  logic reset, enable, word_strobe, out_ready;
  logic [1:0] width_cfg, crt_3;
  logic load_lanes, advance, byte_valid, busy, overrun, sync_lost;
  int checks = 0, errors = 0, cyc = 0;
  int n_load, n_adv, n_ovr, n_lost, first_cyc, last_cyc;
  bit mon_on = 1'b0;
  int exp_q[$];
  typedef struct {
    logic [1:0] w0;
    logic [1:0] w1;
    int bpw;
    int words;
  } vec_t;
  vec_t vecs[5];

  byte_joining_ctrl dut (
    .clk1Mhz(clk1Mhz), .reset(reset), .enable(enable), .width_cfg(width_cfg),
    .word_strobe(word_strobe), .out_ready(out_ready), .load_lanes(load_lanes),
    .advance(advance), .crt_3(crt_3), .byte_valid(byte_valid), .busy(busy),
    .overrun(overrun), .sync_lost(sync_lost)
  );

  always #5 clk1Mhz = ~clk1Mhz;
  always @(posedge clk1Mhz) cyc <= cyc + 1;

  always @(negedge clk1Mhz) if (mon_on) begin
    if (load_lanes) n_load++;
    if (advance) n_adv++;
    if (overrun) n_ovr++;
    if (sync_lost) n_lost++;
    if (byte_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL byte_unexpected: got crt_3=%0d, required no byte at cycle %0d", crt_3, cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(crt_3) != e) begin
          errors++;
          $display("FAIL byte_lane: got crt_3=%0d, required %0d at cycle %0d", crt_3, e, cyc);
        end
      end
      if (first_cyc < 0) first_cyc = cyc;
      last_cyc = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk1Mhz);
    #1;
  endtask

  task automatic clr;
    n_load = 0; n_adv = 0; n_ovr = 0; n_lost = 0; first_cyc = -1; last_cyc = -1;
  endtask

  task automatic push_word(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(i);
  endtask

  task automatic strobe_word;
    word_strobe = 1'b1;
    tick;
    word_strobe = 1'b0;
    repeat (3) tick;
  endtask

  task automatic do_reset;
    reset = 1'b1; enable = 1'b0; word_strobe = 1'b0; out_ready = 1'b1;
    repeat (2) tick;
    reset = 1'b0;
    exp_q.delete();
    clr;
    mon_on = 1'b1;
  endtask

  // leaves the bench on the cycle where the next period-4 strobe is due, FSM in RUN
  task automatic align;
    clr;
    enable = 1'b1;
    tick;
    repeat (3) strobe_word;
    chk("align_no_load", n_load, 0);
  endtask

  initial begin
    width_cfg = 2'd3;
    vecs[0] = '{2'd3, 2'd3, 4, 4};
    vecs[1] = '{2'd2, 2'd0, 4, 3};
    vecs[2] = '{2'd1, 2'd1, 2, 4};
    vecs[3] = '{2'd1, 2'd3, 2, 3};
    vecs[4] = '{2'd0, 2'd3, 1, 4};

    do_reset;
    chk("reset_outs", {load_lanes, advance, crt_3, byte_valid, busy, overrun, sync_lost}, 0);

    width_cfg = 2'd3;
    align;
    push_word(4);
    word_strobe = 1'b1;
    tick;
    word_strobe = 1'b0;
    chk("lat_load", {load_lanes, busy}, 2'b11);
    tick;
    chk("lat_adv", {advance, byte_valid}, 2'b10);
    tick;
    chk("lat_first_byte", {byte_valid, crt_3}, 3'b100);
    repeat (4) tick;
    chk("lat_drained", exp_q.size(), 0);
    enable = 1'b0;
    tick;

    foreach (vecs[v]) begin
      do_reset;
      width_cfg = vecs[v].w0;
      align;
      for (int k = 0; k < vecs[v].words; k++) begin
        if (k == 1) width_cfg = vecs[v].w1;
        push_word(vecs[v].bpw);
        strobe_word;
      end
      repeat (3) tick;
      chk($sformatf("vec%0d_drained", v), exp_q.size(), 0);
      chk($sformatf("vec%0d_loads", v), n_load, vecs[v].words);
      chk($sformatf("vec%0d_no_ovr_lost", v), n_ovr + n_lost, 0);
      if (vecs[v].bpw == 4)
        chk($sformatf("vec%0d_continuous", v), last_cyc - first_cyc + 1, 4 * vecs[v].words);
      enable = 1'b0;
      tick;
    end

    do_reset;
    width_cfg = 2'd3;
    align;
    clr;
    for (int c = 0; c <= 26; c++) begin
      word_strobe = c inside {0, 4, 8, 12, 16};
      out_ready = !(c >= 5 && c <= 14);
      if (c inside {0, 4, 16}) push_word(4);
      if (c == 9) chk("ovr_third_strobe", {overrun, load_lanes}, 2'b10);
      if (c == 10) chk("bp_frozen", {byte_valid, crt_3}, 3'b110);
      if (c == 17) chk("sim_adv_load", {advance, load_lanes, overrun}, 3'b110);
      if (c == 25) chk("gap_lost", {sync_lost, byte_valid, crt_3, busy}, 5'b10000);
      if (c == 26) chk("gap_lost_pulse", sync_lost, 0);
      tick;
    end
    chk("bp_loads", n_load, 3);
    chk("bp_overruns", n_ovr, 2);
    chk("bp_advances", n_adv, 3);
    chk("bp_lost", n_lost, 1);
    chk("bp_drained", exp_q.size(), 0);

    do_reset;
    width_cfg = 2'd3;
    align;
    clr;
    for (int c = 0; c <= 15; c++) begin
      word_strobe = c inside {0, 7, 10, 14};
      out_ready = c < 7;
      if (c == 0) push_word(4);
      if (c == 11) chk("early_lost", {sync_lost, byte_valid, crt_3, busy, load_lanes, overrun}, 7'b1000000);
      if (c == 12) chk("early_lost_pulse", sync_lost, 0);
      if (c == 15) chk("realign_no_load", load_lanes, 0);
      tick;
    end
    chk("early_loads", n_load, 2);
    chk("early_drained", exp_q.size(), 0);

    for (int mode = 0; mode < 2; mode++) begin
      do_reset;
      width_cfg = 2'd3;
      align;
      for (int c = 0; c <= 5; c++) begin
        word_strobe = c == 0 || c == 4;
        if (c == 0) push_word(3);
        if (c == 5) begin
          if (mode == 1) reset = 1'b1;
          else enable = 1'b0;
        end
        tick;
      end
      chk($sformatf("abort%0d_outs", mode),
          {load_lanes, advance, crt_3, byte_valid, busy, overrun, sync_lost}, 0);
      chk($sformatf("abort%0d_bytes", mode), exp_q.size(), 0);
      reset = 1'b0;
      align;
      push_word(4);
      strobe_word;
      repeat (3) tick;
      chk($sformatf("abort%0d_reload", mode), n_load, 1);
      chk($sformatf("abort%0d_drained", mode), exp_q.size(), 0);
      enable = 1'b0;
      tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
